// File: rtl/poci_burst_readout.sv
// POCI burst readout engine: serialises a run of DATA_W-bit registers from a flat
// register bank onto serial_out_o, auto-incrementing the address with wrap to 1.
module poci_burst_readout #(
  parameter int NUM_REGS  = 59,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       sclk,
  input  logic                       rstn,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          start_addr_i,
  input  logic [ADDR_W-1:0]          burst_len_i,
  input  logic [NUM_REGS*DATA_W-1:0] reg_bus_i,
  output logic                       serial_out_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       addr_err_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ser_q, ser_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_nx_s;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && (a <= ADDR_W'(NUM_REGS));
  endfunction

  // Out-of-range and reserved addresses read as zero.
  function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0]          a,
                                                input logic [NUM_REGS*DATA_W-1:0] bus);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 1; i <= NUM_REGS; i++) begin
      if (a == ADDR_W'(i)) begin
        w = bus[i*DATA_W-1 -: DATA_W];
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  assign addr_nx_s = (addr_q >= ADDR_W'(NUM_REGS)) ? ADDR_W'(1) : addr_q + ADDR_W'(1);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ser_d   = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = start_addr_i;
          rem_d   = burst_len_i;
          err_d   = 1'b0;
          state_d = (burst_len_i != '0) ? S_LOAD : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        shreg_d = word_at(addr_q, reg_bus_i);
        cnt_d   = CNT_TOP;
        err_d   = err_q | ~addr_ok(addr_q);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (MSB_FIRST) begin
          ser_d   = shreg_q[DATA_W-1];
          shreg_d = shreg_q << 1;
        end else begin
          ser_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
        cnt_d = cnt_q - CNT_W'(1);
        // Reload on the last bit so the next word follows with no gap.
        if (cnt_q == '0) begin
          if (rem_q > ADDR_W'(1)) begin
            addr_d  = addr_nx_s;
            rem_d   = rem_q - ADDR_W'(1);
            shreg_d = word_at(addr_nx_s, reg_bus_i);
            cnt_d   = CNT_TOP;
            err_d   = err_q | ~addr_ok(addr_nx_s);
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign serial_out_o = ser_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign addr_err_o   = err_q;

endmodule

// File: tb/tb_poci_burst_readout.sv
// Bench for poci_burst_readout: LSB-first and MSB-first instances share stimulus and
// are checked every cycle against a timeline model, plus literal stream checks.
module tb_poci_burst_readout;
  localparam int NR = 59;
  localparam int DW = 8;
  localparam int AW = 8;

  logic              sclk  = 1'b0;
  logic              rstn  = 1'b0;
  logic              start = 1'b0;
  logic [AW-1:0]     saddr = '0;
  logic [AW-1:0]     blen  = '0;
  logic [NR*DW-1:0]  bus   = '0;
  logic ser_l, busy_l, done_l, err_l;
  logic ser_m, busy_m, done_m, err_m;

  poci_burst_readout #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .MSB_FIRST(1'b0)) u_lsb (
    .sclk(sclk), .rstn(rstn), .start_i(start), .start_addr_i(saddr), .burst_len_i(blen),
    .reg_bus_i(bus), .serial_out_o(ser_l), .busy_o(busy_l), .done_o(done_l), .addr_err_o(err_l));

  poci_burst_readout #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .MSB_FIRST(1'b1)) u_msb (
    .sclk(sclk), .rstn(rstn), .start_i(start), .start_addr_i(saddr), .burst_len_i(blen),
    .reg_bus_i(bus), .serial_out_o(ser_m), .busy_o(busy_m), .done_o(done_m), .addr_err_o(err_m));

  always #5 sclk = ~sclk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Timeline model: edge e after an accepted start; word n loads at edge 1+n*DW,
  // its bit k appears at edge 2+n*DW+k, burst ends at edge 2+N*DW.
  logic          m_active = 1'b0;
  logic          m_ser_l  = 1'b0;
  logic          m_ser_m  = 1'b0;
  logic          m_busy   = 1'b0;
  logic          m_done   = 1'b0;
  logic          m_err    = 1'b0;
  int            m_t = 0, m_n = 0, m_start = 0;
  logic [DW-1:0] m_snap [0:255];

  function automatic int word_addr(input int s, input int n);
    if (n == 0) return s;
    if (s >= 1 && s <= NR) return ((s - 1 + n) % NR) + 1;
    return ((n - 1) % NR) + 1;
  endfunction

  initial begin
    int e, a, k, n;
    forever begin
      @(posedge sclk or negedge rstn);
      if (!rstn) begin
        m_active = 1'b0; m_ser_l = 1'b0; m_ser_m = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1'b1; m_t = 1; m_n = int'(blen); m_start = int'(saddr);
          m_err = 1'b0; m_busy = 1'b1; m_done = (m_n == 0); m_ser_l = 1'b0; m_ser_m = 1'b0;
        end
      end else begin
        e = m_t;
        m_t++;
        if ((m_n == 0 && e == 1) || (m_n > 0 && e == 2 + m_n * DW)) begin
          m_active = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_ser_l = 1'b0; m_ser_m = 1'b0;
        end else begin
          if (e >= 2) begin
            k = (e - 2) % DW;
            n = (e - 2) / DW;
            m_ser_l = m_snap[n][k];
            m_ser_m = m_snap[n][DW-1-k];
          end
          if ((e - 1) % DW == 0 && (e - 1) / DW < m_n) begin
            n = (e - 1) / DW;
            a = word_addr(m_start, n);
            if (a >= 1 && a <= NR) m_snap[n] = bus[a*DW-1 -: DW];
            else begin
              m_snap[n] = '0;
              m_err = 1'b1;
            end
          end
          m_done = (e == 1 + m_n * DW);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge sclk);
      check("cycle", {56'd0, ser_l, busy_l, done_l, err_l, ser_m, busy_m, done_m, err_m},
                     {56'd0, m_ser_l, m_busy, m_done, m_err, m_ser_m, m_busy, m_done, m_err});
    end
  end

  task automatic set_reg(input int a, input logic [DW-1:0] v);
    bus[a*DW-1 -: DW] = v;
  endtask

  // Called just after a negedge; returns just after the negedge following edge 0.
  task automatic do_start(input int a, input int l);
    saddr = AW'(a);
    blen  = AW'(l);
    start = 1'b1;
    @(negedge sclk);
    start = 1'b0;
  endtask

  task automatic capture(input int nbits, output logic [63:0] lsb, output logic [63:0] msb);
    lsb = '0;
    msb = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge sclk);
      lsb[i] = ser_l;
      msb = {msb[62:0], ser_m};
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy_l && c < 1000) begin
      @(negedge sclk);
      c++;
    end
    check("idle_timeout", {63'd0, busy_l}, 64'd0);
  endtask

  logic [63:0] lsb, msb;

  initial begin
    repeat (2) @(negedge sclk);
    check("reset_state", {60'd0, ser_l, busy_l, done_l, err_l}, 64'd0);
    rstn = 1'b1;
    @(negedge sclk);

    // Single LSB-first word.
    set_reg(3, 8'hA5);
    do_start(3, 1);
    @(negedge sclk);
    check("t1_err", {63'd0, err_l}, 64'd0);
    capture(8, lsb, msb);
    check("t1_bits", lsb[7:0], 64'hA5);
    check("t1_done", {62'd0, done_l, busy_l}, 64'd3);
    @(negedge sclk);
    check("t1_end", {61'd0, busy_l, done_l, ser_l}, 64'd0);

    // Wrapping three-word burst.
    set_reg(58, 8'h81); set_reg(59, 8'h3C); set_reg(1, 8'hFF);
    do_start(58, 3);
    @(negedge sclk);
    capture(24, lsb, msb);
    check("t2_msb_bits", msb[23:0], 64'h813CFF);
    check("t2_lsb_bits", lsb[23:0], 64'hFF3C81);
    check("t2_err", {63'd0, err_m}, 64'd0);
    check("t2_done", {63'd0, done_m}, 64'd1);
    @(negedge sclk);
    check("t2_busy_low", {63'd0, busy_m}, 64'd0);

    // Reserved start address.
    set_reg(1, 8'h01);
    do_start(0, 2);
    @(negedge sclk);
    check("t3_err_set", {62'd0, err_l, err_m}, 64'd3);
    capture(16, lsb, msb);
    check("t3_bits", lsb[15:0], 64'h0100);
    @(negedge sclk);
    check("t3_err_sticky", {63'd0, err_l}, 64'd1);
    do_start(3, 1);
    check("t3_err_clear", {63'd0, err_l}, 64'd0);
    wait_idle();

    // Zero-length burst.
    do_start(5, 0);
    check("t4_done", {61'd0, done_l, busy_l, ser_l}, 64'd6);
    @(negedge sclk);
    check("t4_end", {61'd0, done_l, busy_l, ser_l}, 64'd0);

    // Ignored mid-burst start and post-load reg_bus changes.
    set_reg(10, 8'h5A); set_reg(11, 8'hC3);
    do_start(10, 2);
    @(negedge sclk);
    set_reg(10, 8'h00);
    lsb = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge sclk);
      lsb[i] = ser_l;
      if (i == 3) begin saddr = AW'(20); blen = AW'(5); start = 1'b1; end
      if (i == 4) start = 1'b0;
      if (i == 8) set_reg(11, 8'hFF);
    end
    check("t5_bits", lsb[15:0], 64'hC35A);
    check("t5_done", {63'd0, done_l}, 64'd1);
    @(negedge sclk);
    check("t5_busy_low", {63'd0, busy_l}, 64'd0);

    // Asynchronous abort part-way through word 2, then a clean burst.
    set_reg(1, 8'h11); set_reg(2, 8'h22); set_reg(3, 8'h33);
    do_start(1, 3);
    @(negedge sclk);
    repeat (20) @(negedge sclk);
    @(posedge sclk);
    #2 rstn = 1'b0;
    #1 check("t6_abort", {56'd0, ser_l, busy_l, done_l, err_l, ser_m, busy_m, done_m, err_m}, 64'd0);
    @(negedge sclk);
    @(negedge sclk);
    rstn = 1'b1;
    set_reg(7, 8'h96);
    do_start(7, 1);
    @(negedge sclk);
    capture(8, lsb, msb);
    check("t6_lsb_bits", lsb[7:0], 64'h96);
    check("t6_msb_bits", msb[7:0], 64'h96);
    check("t6_done", {63'd0, done_l}, 64'd1);
    @(negedge sclk);
    check("t6_busy_low", {63'd0, busy_l}, 64'd0);

    repeat (2) @(negedge sclk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/poci_burst_readout.md
# poci_burst_readout

Parametrised POCI readout engine for the configuration/status register bank. On a start request it serialises one or more DATA_W-bit registers onto serial_out, beginning at a given address and auto-incrementing through a burst. Words are sent back-to-back with no gap cycles. It replaces the fixed 8-bit, single-word mux plus shift register with one block that handles configurable width and depth, burst length, bit order, and address-error flagging.

## Interface
- NUM_REGS, 59: number of readable registers, at addresses 1..NUM_REGS; address 0 is reserved.
- DATA_W, 8: register width in bits.
- ADDR_W, 8: address and burst-length width; must satisfy 2^ADDR_W > NUM_REGS.
- MSB_FIRST, 0: 0 = LSB shifted first; 1 = MSB shifted first.
- sclk  in  1  shift clock; all state updates on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  burst request, synchronous to sclk; sampled only in IDLE.
- start_addr  in  ADDR_W  address of the first word.
- burst_len  in  ADDR_W  number of words to send; 0 means no data.
- reg_bus  in  NUM_REGS*DATA_W  flat register bank; register a occupies bits [a*DATA_W-1 -: DATA_W].
- serial_out  out  1  registered serial data.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at the end of every accepted burst.
- addr_err  out  1  sticky flag: some word in the current or last burst used an invalid address.

## Operation
- States are IDLE, LOAD, SHIFT and DONE.
- Reset values: state IDLE, serial_out 0, busy 0, done 0, addr_err 0; the shift register, address and counters are all 0.
- IDLE:
  - start=1 latches addr=start_addr and remaining=burst_len, and clears addr_err.
  - If burst_len≠0 the next state is LOAD; otherwise it is DONE.
  - start=0 keeps the state in IDLE with serial_out held at 0.
- LOAD (1 cycle):
  - shreg <= word(addr) and bit_cnt <= DATA_W-1, then go to SHIFT.
  - word(a) is reg_bus[a] for 1≤a≤NUM_REGS.
  - For a=0 or a>NUM_REGS, word(a) is all zeros and addr_err is set.
- SHIFT, every cycle:
  - serial_out <= shreg[0] and shreg shifts right (MSB_FIRST=0).
  - serial_out <= shreg[DATA_W-1] and shreg shifts left (MSB_FIRST=1).
  - bit_cnt decrements.
- SHIFT, when bit_cnt==0 and remaining>1:
  - addr <= addr_next, remaining decrements, shreg <= word(addr_next), bit_cnt <= DATA_W-1.
  - The state stays in SHIFT, so there is no gap bit between words.
- SHIFT, when bit_cnt==0 and remaining==1: go to DONE.
- Address increment: addr_next = 1 if addr ≥ NUM_REGS, else addr+1. Reserved address 0 is never produced by increment.
- DONE (1 cycle): done=1; on exit serial_out <= 0 and state <= IDLE.
- Each word's data is snapshotted when that word is loaded; later changes on reg_bus do not affect the bits already loaded.
- start is ignored while busy=1; there is no queuing.
- Asserting rstn low in any state aborts immediately to the reset values; a partial word is discarded.

## Timing
- Edge numbering: the edge that samples start=1 is edge 0.
- Edge 1: LOAD completes.
- Bit k of word n is driven by edge 2 + n*DATA_W + k and is valid until the next edge.
- The last bit of an N-word burst is driven at edge 1 + N*DATA_W, where the state enters DONE.
- done is high for the single cycle between edges 1+N*DATA_W and 2+N*DATA_W, coincident with the last bit.
- Edge 2 + N*DATA_W: serial_out returns to 0, busy falls, and the block can accept a new start.
- Burst duration is N*DATA_W + 2 cycles from start to IDLE.
- burst_len=0: DONE is entered at edge 0, done is high for one cycle, and serial_out stays 0.
- busy rises on edge 0 and falls on the edge that leaves DONE.
- addr_err changes only on an accepted start, which clears it, or on a word load, which can set it.

## Test plan
- Defaults, reg3=8'hA5, start_addr=3, burst_len=1 -> serial_out on edges 2..9 is 1,0,1,0,0,1,0,1; done high after edge 9; busy low after edge 10.
- MSB_FIRST=1, reg58=8'h81, reg59=8'h3C, reg1=8'hFF, start_addr=58, burst_len=3 -> 24 gapless bits 10000001 00111100 11111111 (the address wraps 59->1); addr_err=0.
- start_addr=0, burst_len=2, reg1=8'h01 -> first word 8'h00, second word 8'h01; addr_err=1 after edge 1, and it clears on the next start with a valid address.
- burst_len=0 -> done pulses at cycle 1 with busy high for exactly 1 cycle; serial_out stays 0.
- A second start pulse mid-burst is ignored; toggling reg_bus for the current word after its load does not change the shifted bits.
- rstn pulsed low at bit 4 of word 2 -> all outputs are 0 immediately; a new start after release produces a clean burst from edge 0.
